// File: rtl/execute.sv
`default_nettype none
// ============================================================================
//  Module      : execute
//  Description : Execute (EX) stage of the 64-bit LEGv8 pipelined datapath.
//                Selects the ALU operand B (register or sign-extended
//                immediate), performs the ALU operation, computes the branch
//                target PC + (imm << 2), forwards the store data and flags a
//                zero ALU result. Results are held in the EX/MEM register.
//  Ports       : clk          - pipeline clock (rising edge)
//                reset        - asynchronous reset, active low
//                AluSrc       - operand B select (0 = readData2_E, 1 = signImm_E)
//                AluControl   - 4-bit ALU operation code
//                PC_E         - PC of the instruction in EX
//                signImm_E    - sign-extended immediate
//                readData1_E  - register operand A
//                readData2_E  - register operand B / store data
//                PCBranch_E   - branch target
//                aluResult_E  - ALU result
//                writeData_E  - store data (readData2_E passthrough)
//                zero_E       - 1 when the ALU result is zero
//  Config      : EXECUTE_COMB_OUT_EN - when defined, the output register is
//                removed and outputs follow inputs combinationally
//                (single-cycle datapath); clk and reset are then unused.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute (
  input  logic        clk,
  input  logic        reset,
  input  logic        AluSrc,
  input  logic [3:0]  AluControl,
  input  logic [63:0] PC_E,
  input  logic [63:0] signImm_E,
  input  logic [63:0] readData1_E,
  input  logic [63:0] readData2_E,
  output logic [63:0] PCBranch_E,
  output logic [63:0] aluResult_E,
  output logic [63:0] writeData_E,
  output logic        zero_E
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  logic [63:0] src_b;
  logic [63:0] alu_result;
  logic [63:0] branch_target;
  logic        alu_zero;

  assign src_b = AluSrc ? signImm_E : readData2_E;

  always_comb begin
    alu_result = 64'd0;
    case (AluControl)
      ALU_AND:  alu_result = readData1_E & src_b;
      ALU_OR:   alu_result = readData1_E | src_b;
      ALU_ADD:  alu_result = readData1_E + src_b;
      ALU_SUB:  alu_result = readData1_E - src_b;
      ALU_PASS: alu_result = src_b;
      ALU_NOR:  alu_result = ~(readData1_E | src_b);
      default:  alu_result = 64'd0;
    endcase
  end

  assign alu_zero = (alu_result == 64'd0);

  // Word offset: the two top immediate bits fall off the shift, sum wraps.
  assign branch_target = PC_E + {signImm_E[61:0], 2'b00};

`ifdef EXECUTE_COMB_OUT_EN

  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  always_comb begin
    PCBranch_E  = branch_target;
    aluResult_E = alu_result;
    writeData_E = readData2_E;
    zero_E      = alu_zero;
  end

`else

  // Reset clears zero_E as well; an empty register does not mean "result 0".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PCBranch_E  <= 64'd0;
      aluResult_E <= 64'd0;
      writeData_E <= 64'd0;
      zero_E      <= 1'b0;
    end else begin
      PCBranch_E  <= branch_target;
      aluResult_E <= alu_result;
      writeData_E <= readData2_E;
      zero_E      <= alu_zero;
    end
  end

`endif

endmodule
`default_nettype wire

// File: tb/tb_execute.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute
//  Description : Self-checking bench for the execute stage. Expected results
//                are pushed to a scoreboard queue when stimulus is driven and
//                popped when the stage produces its output.
//  Config      : EXECUTE_COMB_OUT_EN - selects zero-latency expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute;

  typedef struct {
    logic [63:0] pcb;
    logic [63:0] alu;
    logic [63:0] wd;
    logic        zero;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        AluSrc;
  logic [3:0]  AluControl;
  logic [63:0] PC_E;
  logic [63:0] signImm_E;
  logic [63:0] readData1_E;
  logic [63:0] readData2_E;
  logic [63:0] PCBranch_E;
  logic [63:0] aluResult_E;
  logic [63:0] writeData_E;
  logic        zero_E;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;

  execute dut (
    .clk         (clk),
    .reset       (reset),
    .AluSrc      (AluSrc),
    .AluControl  (AluControl),
    .PC_E        (PC_E),
    .signImm_E   (signImm_E),
    .readData1_E (readData1_E),
    .readData2_E (readData2_E),
    .PCBranch_E  (PCBranch_E),
    .aluResult_E (aluResult_E),
    .writeData_E (writeData_E),
    .zero_E      (zero_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h required 0x%016h", tag, got, exp);
    end
  endtask

  // Independent reference model of the stage.
  function automatic exp_t model(input logic src, input logic [3:0] ctl,
                                 input logic [63:0] pc, input logic [63:0] imm,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [63:0] bb;
    bb = src ? imm : b;
    case (ctl)
      4'h0:    e.alu = a & bb;
      4'h1:    e.alu = a | bb;
      4'h2:    e.alu = a + bb;
      4'h6:    e.alu = a - bb;
      4'h7:    e.alu = bb;
      4'hC:    e.alu = ~(a | bb);
      default: e.alu = 64'd0;
    endcase
    e.pcb  = pc + (imm * 64'd4);
    e.wd   = b;
    e.zero = (e.alu == 64'd0);
    return e;
  endfunction

  task automatic drive(input logic src, input logic [3:0] ctl, input logic [63:0] pc,
                       input logic [63:0] imm, input logic [63:0] a, input logic [63:0] b);
    AluSrc      = src;
    AluControl  = ctl;
    PC_E        = pc;
    signImm_E   = imm;
    readData1_E = a;
    readData2_E = b;
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    check_value({tag, "_sb_size"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_value({tag, "_pcb"},  PCBranch_E,  e.pcb);
      check_value({tag, "_alu"},  aluResult_E, e.alu);
      check_value({tag, "_wd"},   writeData_E, e.wd);
      check_value({tag, "_zero"}, 64'(zero_E), 64'(e.zero));
    end
  endtask

  // Drive one vector, push its expected result, compare when it emerges.
  task automatic run_vec(input string tag, input logic src, input logic [3:0] ctl,
                         input logic [63:0] pc, input logic [63:0] imm,
                         input logic [63:0] a, input logic [63:0] b, input exp_t e);
    @(negedge clk);
    drive(src, ctl, pc, imm, a, b);
    sb_q.push_back(e);
`ifdef EXECUTE_COMB_OUT_EN
    #1;
`else
    @(posedge clk);
    #1;
`endif
    compare_outputs(tag);
  endtask

  function automatic exp_t mk(input logic [63:0] pcb, input logic [63:0] alu,
                              input logic [63:0] wd, input logic z);
    exp_t e;
    e.pcb = pcb; e.alu = alu; e.wd = wd; e.zero = z;
    return e;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive(1'b0, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0);

`ifndef EXECUTE_COMB_OUT_EN
    // Reset state, including across clock edges.
    drive(1'b1, 4'h2, 64'h100, 64'h3, 64'h7, 64'h9);
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_pcb",  PCBranch_E,  64'd0);
    check_value("rst_alu",  aluResult_E, 64'd0);
    check_value("rst_wd",   writeData_E, 64'd0);
    check_value("rst_zero", 64'(zero_E), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors with hand-derived expectations.
    run_vec("passb", 1'b1, 4'b0111, 64'd2, 64'd4, 64'd1, 64'd5, mk(64'd18, 64'd4, 64'd5, 1'b0));
    run_vec("sub0",  1'b0, 4'b0110, 64'd0, 64'd0, 64'h1234, 64'h1234, mk(64'd0, 64'd0, 64'h1234, 1'b1));
    run_vec("and",   1'b0, 4'b0000, 64'd0, 64'd0, 64'hF0F0, 64'h0FF0, mk(64'd0, 64'h00F0, 64'h0FF0, 1'b0));
    run_vec("or",    1'b0, 4'b0001, 64'd0, 64'd0, 64'hF0F0, 64'h0FF0, mk(64'd0, 64'hFFF0, 64'h0FF0, 1'b0));
    run_vec("nor",   1'b0, 4'b1100, 64'd0, 64'd0, 64'hF0F0, 64'h0FF0,
            mk(64'd0, 64'hFFFF_FFFF_FFFF_000F, 64'h0FF0, 1'b0));
    run_vec("undef", 1'b0, 4'b1111, 64'd0, 64'd0, 64'hF0F0, 64'h0FF0, mk(64'd0, 64'd0, 64'h0FF0, 1'b1));
    run_vec("addwrap", 1'b0, 4'b0010, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
            mk(64'd0, 64'd0, 64'd1, 1'b1));
    run_vec("pcwrap", 1'b1, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 64'd3, 64'd6,
            mk(64'd0, 64'd4, 64'd6, 1'b0));
    run_vec("negimm", 1'b1, 4'b0010, 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd2,
            mk(64'd4, 64'd0, 64'd2, 1'b1));
    run_vec("immtop", 1'b1, 4'b0111, 64'd0, 64'hC000_0000_0000_0001, 64'd0, 64'hAA,
            mk(64'd4, 64'hC000_0000_0000_0001, 64'hAA, 1'b0));

    // Latency: input changes between edges must not (or must, in comb mode) show.
    @(negedge clk);
    drive(1'b0, 4'b0010, 64'd16, 64'd1, 64'd3, 64'd4);
    sb_q.push_back(mk(64'd20, 64'd7, 64'd4, 1'b0));
`ifdef EXECUTE_COMB_OUT_EN
    #1;
    compare_outputs("lat_comb");
`else
    @(posedge clk);
    #1;
    compare_outputs("lat_edge");
    drive(1'b0, 4'b0001, 64'd100, 64'd2, 64'h10, 64'h20);
    #2;
    check_value("lat_hold_alu", aluResult_E, 64'd7);
    check_value("lat_hold_pcb", PCBranch_E,  64'd20);
    check_value("lat_hold_wd",  writeData_E, 64'd4);
    sb_q.push_back(mk(64'd108, 64'h30, 64'h20, 1'b0));
    @(posedge clk);
    #1;
    compare_outputs("lat_next");

    // Reset mid-stream: cleared at once, held across edges, then resumes.
    @(negedge clk);
    drive(1'b0, 4'b0010, 64'd40, 64'd5, 64'd11, 64'd22);
    #2;
    reset = 1'b0;
    #1;
    check_value("mrst_alu",  aluResult_E, 64'd0);
    check_value("mrst_pcb",  PCBranch_E,  64'd0);
    check_value("mrst_wd",   writeData_E, 64'd0);
    check_value("mrst_zero", 64'(zero_E), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_value("mrst_hold_alu", aluResult_E, 64'd0);
    check_value("mrst_hold_wd",  writeData_E, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    sb_q.push_back(mk(64'd60, 64'd33, 64'd22, 1'b0));
    @(posedge clk);
    #1;
    compare_outputs("mrst_rel");
`endif

    // Randomised vectors against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  ctl;
      logic        src;
      logic [63:0] pc, imm, a, b;
      logic [3:0]  codes [8];
      codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h5, 4'hF};
      ctl = codes[$urandom_range(0, 7)];
      src = 1'($urandom_range(0, 1));
      pc  = {$urandom, $urandom};
      imm = {$urandom, $urandom};
      a   = {$urandom, $urandom};
      b   = (i % 6 == 0) ? a : {$urandom, $urandom};
      run_vec($sformatf("rnd%0d", i), src, ctl, pc, imm, a, b, model(src, ctl, pc, imm, a, b));
    end

    check_value("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
